// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg: ALU control encodings, funct constants and MDU FSM states. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MUL   = 6'b011100;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  function automatic logic [2:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [2:0] r;
    r = ALU_ADD;
    if (op == 2'b01) begin
      r = ALU_SUB;
    end else if (op == 2'b10) begin
      case (funct)
        F_SUB:   r = ALU_SUB;
        F_AND:   r = ALU_AND;
        F_OR:    r = ALU_OR;
        F_SLT:   r = ALU_SLT;
        F_MUL:   r = ALU_MUL;
        default: r = ALU_ADD;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq: iterative unsigned shift-add multiply / restoring divide (one bit
// per cycle). Divide datapath present only with MDU_DIV_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             busy_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] work_q;
  logic [2*WIDTH-1:0] work_d;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     mul_sum;

  // Multiplier sits in the low half and is consumed LSB-first; the carry of
  // each partial add is kept by shifting it into the top of the product.
  assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  // Partial remainder shifted left with the next dividend bit; a zero divisor
  // always "fits", which naturally yields all-ones quotient and rem = dividend.
  assign div_rem  = work_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = (div_rem >= {1'b0, opnd_q});
  assign div_diff = div_rem[WIDTH-1:0] - opnd_q;
  assign div_next = {(div_ge ? div_diff : div_rem[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
  assign work_d   = div_q ? div_next : mul_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= 1'b0;
    end else if (start_i) begin
      div_q <= div_i;
    end
  end
`else
  logic unused_div;
  assign unused_div = div_i;
  assign work_d     = mul_next;
`endif

  assign last_o = busy_i && (cnt_q == CW'(WIDTH - 1));
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      work_q <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start_i) begin
      work_q <= {{WIDTH{1'b0}}, a_i};
      opnd_q <= b_i;
      cnt_q  <= '0;
    end else if (busy_i) begin
      work_q <= work_d;
      cnt_q  <= cnt_q + CW'(1);
      if (last_o) begin
        {hi_q, lo_q} <= work_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_mdu.sv
// ---------------------------------------------------------------------------
// alu_control_mdu: ALU control decode plus IDLE/BUSY/DONE sequencing of the
// multi-cycle MULTU/DIVU unit. DIVU enabled by macro MDU_DIV_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module alu_control_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Function,
  input  logic             valid,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [2:0]       ALU_Control,
  output logic [1:0]       hilo_rd,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  mdu_state_e state_q;
  logic       w_rtype;
  logic       w_is_div;
  logic       w_start;
  logic       w_busy;
  logic       w_last;

  assign w_rtype = (ALUOp == 2'b10);
`ifdef MDU_DIV_EN
  assign w_is_div = (Function == F_DIVU);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_start = !reset && valid && w_rtype && (state_q == S_IDLE)
                   && ((Function == F_MULTU) || w_is_div);
  assign w_busy  = (state_q == S_BUSY);

  always_comb begin
    ALU_Control = alu_decode(ALUOp, Function);
    hilo_rd     = HILO_NONE;
    if (w_rtype && (Function == F_MFHI)) hilo_rd = HILO_HI;
    if (w_rtype && (Function == F_MFLO)) hilo_rd = HILO_LO;
  end

  // Reset masks the handshake outputs in the same cycle it is asserted.
  assign stall = !reset && (w_start || w_busy);
  assign done  = !reset && (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (w_start) state_q <= S_BUSY;
        S_BUSY:  if (w_last)  state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  mdu_seq #(
    .WIDTH(WIDTH)
  ) u_mdu_seq (
    .clk     (clk),
    .reset   (reset),
    .start_i (w_start),
    .div_i   (w_is_div),
    .busy_i  (w_busy),
    .a_i     (rs_val),
    .b_i     (rt_val),
    .last_o  (w_last),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mdu.sv
// ---------------------------------------------------------------------------
// tb_alu_control_mdu: scoreboard bench for alu_control_mdu (WIDTH = 32).
// Honours MDU_DIV_EN for the DIVU expectations. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module tb_alu_control_mdu;
  localparam int W = 32;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MUL   = 6'b011100;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ALUOp;
  logic [5:0]   Function;
  logic         valid;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic [2:0]   ALU_Control;
  logic [1:0]   hilo_rd;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   cur_hi = '0;
  logic [W-1:0]   cur_lo = '0;

  always #5 clk = ~clk;

  alu_control_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ALUOp       (ALUOp),
    .Function    (Function),
    .valid       (valid),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .ALU_Control (ALU_Control),
    .hilo_rd     (hilo_rd),
    .stall       (stall),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: the architectural meaning of each instruction.
  function automatic logic [2:0] ref_alu(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return 3'b100;
    if (op != 2'b10) return 3'b010;
    case (f)
      FN_ADD:  return 3'b010;
      FN_SUB:  return 3'b100;
      FN_AND:  return 3'b000;
      FN_OR:   return 3'b001;
      FN_SLT:  return 3'b110;
      FN_MUL:  return 3'b101;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [1:0] ref_hilo(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b10 && f == FN_MFHI) return 2'b01;
    if (op == 2'b10 && f == FN_MFLO) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2*W-1:0] ref_mdu(input logic [5:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] wide_a;
    logic [2*W-1:0] wide_b;
    wide_a = (2*W)'(a);
    wide_b = (2*W)'(b);
    if (f == FN_MULTU) return wide_a * wide_b;
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  // Monitor: every done pulse retires the oldest outstanding operation.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    if (done === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: done=1 with no operation outstanding, hi=0x%0h lo=0x%0h",
                 hi, lo);
      end else begin
        e = exp_q.pop_front();
        if ({hi, lo} !== e) begin
          n_fail++;
          $display("FAIL result: got {hi,lo}=0x%0h expected 0x%0h", {hi, lo}, e);
        end
      end
    end
  end

  task automatic run_mdu(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] e;
    bit             starts;
    bit             held_ok;
    int             n;
    starts = (f == FN_MULTU) || (DIV_EN && (f == FN_DIVU));
    e      = ref_mdu(f, a, b);
    @(posedge clk); #1;
    valid = 1'b1; ALUOp = 2'b10; Function = f; rs_val = a; rt_val = b;
    @(negedge clk);
    check("stall_start", 64'(stall), 64'(starts));
    if (starts) begin
      exp_q.push_back(e);
      n       = 1;
      held_ok = 1'b1;
      for (int i = 0; i < 4 * W; i++) begin
        @(posedge clk); #1;
        rs_val = $urandom; rt_val = $urandom;
        @(negedge clk);
        if (!stall) break;
        n++;
        if (hi !== cur_hi || lo !== cur_lo || done !== 1'b0) held_ok = 1'b0;
      end
      check("stall_cycles", 64'(n), 64'(W + 1));
      check("hilo_held_busy", 64'(held_ok), 64'(1));
      check("done_after_busy", 64'(done), 64'(1));
      cur_hi = e[2*W-1:W];
      cur_lo = e[W-1:0];
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("nostart_stall", 64'(stall), 64'(0));
        check("nostart_done", 64'(done), 64'(0));
        check("nostart_hilo", {hi, lo}, {cur_hi, cur_lo});
      end
    end
  endtask

  task automatic read_hilo(input logic [5:0] f);
    @(posedge clk); #1;
    valid = 1'b1; ALUOp = 2'b10; Function = f; rs_val = $urandom; rt_val = $urandom;
    @(negedge clk);
    check("mf_hilo_rd", 64'(hilo_rd), 64'(ref_hilo(2'b10, f)));
    check("mf_value", 64'((f == FN_MFHI) ? hi : lo), 64'((f == FN_MFHI) ? cur_hi : cur_lo));
    check("mf_stall", 64'(stall), 64'(0));
  endtask

  task automatic decode_vec(input logic [1:0] op, input logic [5:0] f, input logic v);
    @(posedge clk); #1;
    ALUOp = op; Function = f; valid = v; rs_val = $urandom; rt_val = $urandom;
    @(negedge clk);
    check("alu_control", 64'(ALU_Control), 64'(ref_alu(op, f)));
    check("hilo_rd", 64'(hilo_rd), 64'(ref_hilo(op, f)));
    check("decode_stall", 64'(stall), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] flist [10];
    logic [1:0] op;
    logic [5:0] f;
    logic       v;
    bit         no_done;
    flist = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MUL, FN_MFHI, FN_MFLO, FN_MULTU, FN_DIVU};

    reset = 1'b1; valid = 1'b0; ALUOp = 2'b00; Function = '0; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_done", 64'(done), 64'(0));

    decode_vec(2'b10, FN_SLT, 1'b1);
    decode_vec(2'b10, 6'b111111, 1'b1);
    decode_vec(2'b01, FN_ADD, 1'b1);
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      f  = (i % 2 == 0) ? flist[$urandom_range(0, 9)] : 6'($urandom);
      v  = 1'($urandom);
      if (op == 2'b10 && (f == FN_MULTU || f == FN_DIVU)) v = 1'b0;
      decode_vec(op, f, v);
    end

    run_mdu(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    read_hilo(FN_MFLO);
    read_hilo(FN_MFHI);

    run_mdu(FN_MULTU, $urandom, $urandom);
    run_mdu(FN_MULTU, $urandom, $urandom);
    read_hilo(FN_MFLO);
    run_mdu(FN_MULTU, 32'd0, $urandom);
    run_mdu(FN_MULTU, $urandom, 32'd1);
    read_hilo(FN_MFHI);

    run_mdu(FN_DIVU, 32'd100, 32'd7);
    read_hilo(FN_MFLO);
    read_hilo(FN_MFHI);
    run_mdu(FN_DIVU, 32'd5, 32'd0);
    read_hilo(FN_MFLO);
    for (int i = 0; i < 3; i++) begin
      run_mdu(FN_DIVU, $urandom, $urandom_range(1, 1 << $urandom_range(1, 31)));
    end
    read_hilo(FN_MFHI);

    // Abandon a multiply with reset in its 10th BUSY cycle.
    @(posedge clk); #1;
    valid = 1'b1; ALUOp = 2'b10; Function = FN_MULTU; rs_val = $urandom; rt_val = $urandom;
    @(negedge clk);
    check("abandon_start_stall", 64'(stall), 64'(1));
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_cycle_stall", 64'(stall), 64'(0));
    check("reset_cycle_done", 64'(done), 64'(0));
    check("reset_cycle_alu", 64'(ALU_Control), 64'(ref_alu(2'b10, FN_MULTU)));
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0;
    @(negedge clk);
    cur_hi = '0;
    cur_lo = '0;
    check("post_reset_stall", 64'(stall), 64'(0));
    check("post_reset_hilo", {hi, lo}, 64'(0));
    no_done = 1'b1;
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || stall !== 1'b0) no_done = 1'b0;
    end
    check("post_reset_quiet", 64'(no_done), 64'(1));

    run_mdu(FN_MULTU, $urandom, $urandom);
    read_hilo(FN_MFLO);

    @(posedge clk); #1 valid = 1'b0;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_control_mdu.md
ALU_CONTROL_MDU -- requirements
Module: alu_control_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width; legal values are even and 8..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port ALUOp  input  2  main-decoder op class.
REQ-005 SHALL have port Function  input  6  instruction funct field.
REQ-006 SHALL have port valid  input  1  instruction present in EX this cycle.
REQ-007 SHALL have port rs_val, rt_val  input  WIDTH each  operands.
REQ-008 SHALL have port ALU_Control  output  3  ALU operation select.
REQ-009 SHALL have port hilo_rd  output  2  01 = read HI, 10 = read LO, 00 = none.
REQ-010 SHALL have port stall  output  1  freeze PC and EX while high.
REQ-011 SHALL have port done  output  1  one-cycle result-written pulse.
REQ-012 SHALL have ports hi, lo  output  WIDTH each  HI/LO registers.

Function
REQ-013 ALU_Control SHALL be combinational: ALUOp 00 -> 010, 01 -> 100, 11 -> 010; ALUOp 10 with funct 100000 -> 010, 100010 -> 100, 100100 -> 000, 100101 -> 001, 101010 -> 110, 011100 -> 101, any other funct -> 010.
REQ-014 hilo_rd SHALL be 01 for ALUOp 10 with funct 010000 (MFHI), 10 for funct 010010 (MFLO), else 00.
REQ-015 Start condition SHALL be: state IDLE, valid = 1, ALUOp = 10, and funct 011001 (MULTU) or 011011 (DIVU).
REQ-016 FSM states SHALL be IDLE, BUSY, DONE: IDLE -> BUSY on start; BUSY -> DONE after exactly WIDTH iterations; DONE -> IDLE unconditionally.
REQ-017 On start, operands and op kind SHALL be latched and the iteration counter set to 0; later changes of rs_val/rt_val SHALL NOT affect the result.
REQ-018 stall SHALL be high in the start cycle (combinational) and in every BUSY cycle, i.e. WIDTH+1 cycles; it SHALL be low in DONE and IDLE.
REQ-019 MULTU SHALL be unsigned shift-add, one bit per BUSY cycle; {hi,lo} = rs_val * rt_val (2*WIDTH bits, no truncation).
REQ-020 DIVU SHALL be unsigned restoring, one quotient bit per BUSY cycle; lo = quotient, hi = remainder.
REQ-021 DIVU with rt_val = 0 SHALL yield lo = all ones and hi = rs_val, same latency, no other indication.
REQ-022 hi and lo SHALL update only on the edge entering DONE; done SHALL be high exactly in the DONE cycle.
REQ-023 A start condition present during DONE SHALL be ignored (the stalled instruction retires in DONE; no restart).
REQ-024 MFHI/MFLO issued in the cycle immediately after DONE SHALL observe the new hi/lo.

Reset
REQ-025 reset high SHALL, at the next edge, force state IDLE, counter 0, hi = 0, lo = 0, latched operands 0, abandoning any operation in flight.
REQ-026 stall and done SHALL be 0 during any cycle in which reset is high, regardless of other inputs.
REQ-027 ALU_Control and hilo_rd SHALL remain pure decode, unaffected by reset.

Configuration
REQ-028 Macro MDU_DIV_EN SHALL, when defined, compile in the divide datapath and DIVU start.
REQ-029 Without MDU_DIV_EN, funct 011011 SHALL NOT start, SHALL give ALU_Control 010 with stall 0, and hi/lo SHALL be unaffected.

Structure
REQ-030 Shared package alu_pkg SHALL hold ALU_Control encodings, funct constants and the FSM state enum.
REQ-031 The iterative multiply/divide datapath SHALL be sub-module mdu_seq (operand latch, counter, shift registers); alu_control_mdu holds decode and FSM.

Verification
REQ-032 ALUOp 10, funct 101010 -> ALU_Control 110, stall 0; funct 111111 -> 010; ALUOp 01 -> 100.
REQ-033 WIDTH 32, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high 33 cycles, done in cycle 34, hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-034 DIVU 100 / 7 -> lo = 14, hi = 2; DIVU 5 / 0 -> lo = 0xFFFFFFFF, hi = 5; operands changed mid-BUSY leave results unchanged.
REQ-035 reset asserted in the 10th BUSY cycle -> next cycle IDLE, stall 0, hi = lo = 0, done never pulses.
REQ-036 MULTU retires, then MFLO in the next cycle -> hilo_rd 10 and lo already holds the product; back-to-back MULTU -> second starts only from IDLE.
REQ-037 Build without MDU_DIV_EN, issue DIVU -> stall 0, done 0, hi/lo unchanged.
